// File: rtl/qmult_arbiter_pkg.sv
// qmult_arb_pkg: shared defaults, requester-id width helper and stage payload type
package qmult_arb_pkg;
   localparam int N_DEF = 32;
   localparam int Q_DEF = 15;
   localparam int NUM_REQ_DEF = 4;

   function automatic int id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int ID_W_DEF = id_w(NUM_REQ_DEF);

   typedef struct packed {
      logic [N_DEF-1:0] a;
      logic [N_DEF-1:0] b;
      logic [ID_W_DEF-1:0] id;
   } stage_t;
endpackage

// File: rtl/qmult_arbiter_if.sv
// qmult_arbiter_if: per-requester operand ports plus the single backpressured result port
interface qmult_arbiter_if
   import qmult_arb_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int NUM_REQ = NUM_REQ_DEF
) ();
   localparam int ID_W = id_w(NUM_REQ);
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_ready;
   logic [NUM_REQ*N-1:0] req_a;
   logic [NUM_REQ*N-1:0] req_b;
   logic res_valid;
   logic res_ready;
   logic [N-1:0] res_data;
   logic res_ovr;
   logic [ID_W-1:0] res_id;
   modport master (
      output req_valid, req_a, req_b, res_ready,
      input req_ready, res_valid, res_data, res_ovr, res_id
   );
   modport slave (
      input req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_data, res_ovr, res_id
   );
endinterface

// File: rtl/qmult_arbiter_qmult.sv
// qmult: combinational sign-magnitude fixed-point multiply with integer-overflow flag
module qmult
   import qmult_arb_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int Q = Q_DEF
) (
   input logic [N-1:0] i_multiplicand,
   input logic [N-1:0] i_multiplier,
   output logic [N-1:0] o_result,
   output logic o_ovr
);
   logic [2*N-3:0] full;
   logic [2*N-3:0] scaled;
   assign full = (2*N-2)'(i_multiplicand[N-2:0]) * (2*N-2)'(i_multiplier[N-2:0]);
   assign scaled = full >> Q;
   // overflow keeps the truncated magnitude; only the flag reports lost integer bits
   assign o_result = {i_multiplicand[N-1] ^ i_multiplier[N-1], scaled[N-2:0]};
   assign o_ovr = |scaled[2*N-3:N-1];
endmodule

// File: rtl/qmult_arbiter_rr.sv
// rr_arbiter: round-robin grant searched from a rotating pointer that moves past each acceptance
module rr_arbiter
   import qmult_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input logic i_clk,
   input logic i_rst,
   input logic [NUM_REQ-1:0] i_valid,
   input logic i_advance,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [id_w(NUM_REQ)-1:0] o_idx
);
   localparam int ID_W = id_w(NUM_REQ);
   logic [ID_W-1:0] prio;
   logic [ID_W:0] s;
   logic [ID_W-1:0] k;
   // scan farthest-first so the nearest valid requester to prio wins
   always_comb begin
      o_grant = '0;
      o_idx = '0;
      s = '0;
      k = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         s = {1'b0, prio} + (ID_W+1)'(i);
         k = (s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(s - (ID_W+1)'(NUM_REQ)) : ID_W'(s);
         if (i_valid[k]) begin
            o_grant = '0;
            o_grant[k] = 1'b1;
            o_idx = k;
         end
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) prio <= '0;
      else if (i_advance) prio <= (o_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_idx + ID_W'(1);
   end
endmodule

// File: rtl/qmult_arbiter.sv
// qmult_arbiter: shares one qmult between NUM_REQ requesters through a
// round-robin grant, a stage-1 operand register and a backpressured result register.
module qmult_arbiter
   import qmult_arb_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int Q = Q_DEF,
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input logic i_clk,
   input logic i_rst,
   qmult_arbiter_if.slave bus
);
   localparam int ID_W = id_w(NUM_REQ);
   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [ID_W-1:0] id;
   } s1_t;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0] idx;
   logic [N-1:0] a_arr [NUM_REQ];
   logic [N-1:0] b_arr [NUM_REQ];
   s1_t s1;
   logic s1_valid, out_load, s1_load, accept;
   logic [N-1:0] prod, res_data;
   logic ovr, res_valid, res_ovr;
   logic [ID_W-1:0] res_id;
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign a_arr[g] = bus.req_a[g*N +: N];
      assign b_arr[g] = bus.req_b[g*N +: N];
   end
   assign out_load = !res_valid | bus.res_ready;
   assign s1_load = !s1_valid | out_load;
   assign accept = s1_load & |bus.req_valid;
   assign bus.req_ready = (s1_load & !i_rst) ? grant : '0;
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_valid(bus.req_valid),
      .i_advance(accept),
      .o_grant(grant),
      .o_idx(idx)
   );
   qmult #(.N(N), .Q(Q)) u_mult (
      .i_multiplicand(s1.a),
      .i_multiplier(s1.b),
      .o_result(prod),
      .o_ovr(ovr)
   );
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1 <= '0;
         res_valid <= 1'b0;
         res_data <= '0;
         res_ovr <= 1'b0;
         res_id <= '0;
      end else begin
         if (s1_load) s1_valid <= accept;
         if (accept) s1 <= '{a: a_arr[idx], b: b_arr[idx], id: idx};
         if (out_load) res_valid <= s1_valid;
         if (out_load & s1_valid) begin
            res_data <= prod;
            res_ovr <= ovr;
            res_id <= s1.id;
         end
      end
   end
   assign bus.res_valid = res_valid;
   assign bus.res_data = res_data;
   assign bus.res_ovr = res_ovr;
   assign bus.res_id = res_id;
endmodule

// File: tb/tb_qmult_arbiter.sv
// tb_qmult_arbiter: directed literal cases plus randomized traffic checked every cycle
// against a queue-based reference of the arbiter and result port.
module tb_qmult_arbiter;
   localparam int N = 32;
   localparam int NR = 4;
   logic clk, rst;
   int tests = 0;
   int fails = 0;
   qmult_arbiter_if #(.N(N), .NUM_REQ(NR)) bus ();
   qmult_arbiter #(.N(N), .Q(15), .NUM_REQ(NR)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int m_prio = 0;
   bit m_shown = 0;
   logic [N-1:0] q_data[$];
   logic q_ovr[$];
   int q_id[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [63:0] m;
      m = (64'(x[N-2:0]) * 64'(y[N-2:0])) >> 15;
      return {m[63:N-1] != 0, x[N-1] ^ y[N-1], m[N-2:0]};
   endfunction

   function automatic int pick(input logic [NR-1:0] v, input int p);
      int r;
      r = -1;
      for (int i = NR - 1; i >= 0; i--) if (v[(p + i) % NR]) r = (p + i) % NR;
      return r;
   endfunction

   function automatic logic [N-1:0] rnd_op();
      logic [N-1:0] v;
      v = $urandom;
      return ($urandom_range(0, 3) == 0) ? v : {v[N-1], 11'b0, v[19:0]};
   endfunction

   // reference: accepted products in order; the head is shown once it has reached the output
   always @(negedge clk) begin : model
      int g;
      logic [NR-1:0] er;
      logic [N:0] r;
      g = pick(bus.req_valid, m_prio);
      er = (!rst && g >= 0 && !(m_shown && !bus.res_ready && q_data.size() == 2)) ? NR'(1) << g : '0;
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      chk("res_valid", 64'(bus.res_valid), 64'(m_shown));
      if (m_shown) begin
         chk("res_data", 64'(bus.res_data), 64'(q_data[0]));
         chk("res_ovr", 64'(bus.res_ovr), 64'(q_ovr[0]));
         chk("res_id", 64'(bus.res_id), 64'(q_id[0]));
      end
      if (rst) begin
         q_data.delete();
         q_ovr.delete();
         q_id.delete();
         m_shown = 0;
         m_prio = 0;
      end else begin
         if (m_shown && bus.res_ready) begin
            void'(q_data.pop_front());
            void'(q_ovr.pop_front());
            void'(q_id.pop_front());
            m_shown = 0;
         end
         if (!m_shown && q_data.size() > 0) m_shown = 1;
         if (er != 0) begin
            r = ref_mul(bus.req_a[g*N +: N], bus.req_b[g*N +: N]);
            q_data.push_back(r[N-1:0]);
            q_ovr.push_back(r[N]);
            q_id.push_back(g);
            m_prio = (g + 1) % NR;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic one(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] ed, input logic eo, input string nm);
      int n;
      step();
      bus.req_valid = '0;
      bus.req_valid[k] = 1'b1;
      bus.req_a[k*N +: N] = a;
      bus.req_b[k*N +: N] = b;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      step();
      bus.req_valid = '0;
      n = 0;
      @(negedge clk);
      while (!bus.res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " data"}, 64'(bus.res_data), 64'(ed));
      chk({nm, " ovr"}, 64'(bus.res_ovr), 64'(eo));
      chk({nm, " id"}, 64'(bus.res_id), 64'(k));
   endtask

   initial begin
      int acc;
      int ids[$];
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.res_ready = 1'b1;
      repeat (2) step();
      @(negedge clk);
      chk("reset res_valid", 64'(bus.res_valid), 64'(0));
      chk("reset res_data", 64'(bus.res_data), 64'(0));
      chk("reset res_ovr", 64'(bus.res_ovr), 64'(0));
      chk("reset res_id", 64'(bus.res_id), 64'(0));
      chk("reset req_ready", 64'(bus.req_ready), 64'(0));
      step();
      rst = 1'b0;

      one(2, 32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0, "single");
      one(0, 32'h8000_C000, 32'h0001_0000, 32'h8001_8000, 1'b0, "sign");
      one(1, 32'h4000_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "overflow");

      step();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      bus.req_valid = '1;
      for (int k = 0; k < NR; k++) begin
         bus.req_a[k*N +: N] = 32'(k + 1) << 15;
         bus.req_b[k*N +: N] = 32'h0001_0000;
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rr grant", 64'(bus.req_ready), 64'(4'b0001 << (i % NR)));
         if (bus.res_valid) ids.push_back(int'(bus.res_id));
         step();
      end
      chk("rr result count", 64'(ids.size()), 64'(6));
      for (int j = 0; j < 4 && j < ids.size(); j++) chk("rr result id", 64'(ids[j]), 64'(j));

      bus.req_valid = '0;
      repeat (4) step();
      bus.res_ready = 1'b0;
      bus.req_valid = '1;
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (|(bus.req_ready & bus.req_valid)) acc++;
         step();
      end
      chk("stall accepts", 64'(acc), 64'(2));
      @(negedge clk);
      chk("stall ready", 64'(bus.req_ready), 64'(0));
      step();
      bus.res_ready = 1'b1;
      bus.req_valid = '0;
      ids.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.res_valid) ids.push_back(int'(bus.res_id));
         step();
      end
      chk("drain count", 64'(ids.size()), 64'(2));
      for (int j = 0; j < 2 && j < ids.size(); j++) chk("drain id", 64'(ids[j]), 64'(j));

      bus.res_ready = 1'b0;
      bus.req_valid = '1;
      repeat (3) step();
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("midreset res_valid", 64'(bus.res_valid), 64'(0));
      chk("midreset req_ready", 64'(bus.req_ready), 64'(0));
      step();
      rst = 1'b0;
      bus.res_ready = 1'b1;
      bus.req_valid = 4'b1010;
      @(negedge clk);
      chk("post-reset grant", 64'(bus.req_ready), 64'(4'b0010));
      step();
      bus.req_valid = '0;
      repeat (3) step();

      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         bus.req_valid = NR'($urandom);
         for (int k = 0; k < NR; k++) begin
            bus.req_a[k*N +: N] = rnd_op();
            bus.req_b[k*N +: N] = rnd_op();
         end
         bus.res_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rst = 1'b0;
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      repeat (6) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
